// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the multi-channel SRAM arbiter.
package sram_arb_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_NCH    = 2;
  localparam int DEF_RD_LAT = 1;
  localparam int MAX_NCH    = 8;

  // Wide enough to name any of up to MAX_NCH channels.
  typedef logic [$clog2(MAX_NCH)-1:0] ch_id_t;

endpackage

// File: rtl/sram_arb_if.sv
// Bundle of sram_arb signals, with views for the design, a driver and a passive observer.
interface sram_arb_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NCH    = 2
) (
  input logic clk
);

  logic                   rst;
  logic [NCH-1:0]         en;
  logic [NCH-1:0]         wr;
  logic [NCH*DATA_W-1:0]  wr_data;
  logic [NCH*ADDR_W-1:0]  addr;
  logic [NCH-1:0]         gnt;
  logic [NCH-1:0]         rd_valid;
  logic [DATA_W-1:0]      rd_data;

  modport DUT (
    input  clk, rst, en, wr, wr_data, addr,
    output gnt, rd_valid, rd_data
  );

  modport testbench (
    input  clk, gnt, rd_valid, rd_data,
    output rst, en, wr, wr_data, addr
  );

  modport monitor (
    input clk, rst, en, wr, wr_data, addr, gnt, rd_valid, rd_data
  );

endinterface

// File: rtl/sram_arb_rr_arbiter.sv
// Round-robin arbiter: the first requester found after the pointer wins.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NCH = DEF_NCH
) (
  input  logic [NCH-1:0] req,
  input  ch_id_t         pointer,
  output logic [NCH-1:0] gnt,
  output ch_id_t         idx
);

  // Walk offsets from farthest to nearest so the channel closest after the pointer overrides.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int off = NCH; off >= 1; off--) begin
      for (int i = 0; i < NCH; i++) begin
        if (req[i] && ((int'(pointer) + off) % NCH) == i) begin
          gnt    = '0;
          gnt[i] = 1'b1;
          idx    = ch_id_t'(i);
        end
      end
    end
  end

endmodule

// File: rtl/sram_arb.sv
// Single-port SRAM shared by NCH requesters through a round-robin arbiter,
// with a fixed-latency read-return pipeline.
module sram_arb
  import sram_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NCH    = DEF_NCH,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        en,
  input  logic [NCH-1:0]        wr,
  input  logic [NCH*DATA_W-1:0] wr_data,
  input  logic [NCH*ADDR_W-1:0] addr,
  output logic [NCH-1:0]        gnt,
  output logic [NCH-1:0]        rd_valid,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  ch_id_t            last_granted;
  ch_id_t            gnt_idx;
  logic [NCH-1:0]    arb_gnt;
  logic              granted;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              pipe_v  [RD_LAT];
  ch_id_t            pipe_ch [RD_LAT];
  logic [DATA_W-1:0] pipe_d  [RD_LAT];

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (en),
    .pointer (last_granted),
    .gnt     (arb_gnt),
    .idx     (gnt_idx)
  );

  assign gnt     = rst ? '0 : arb_gnt;
  assign granted = |gnt;

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt[i]) begin
        sel_wr    = wr[i];
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Memory has no reset so writes granted before a reset survive it.
  always_ff @(posedge clk) begin
    if (granted && sel_wr) mem[sel_addr] <= sel_wdata;
  end

  // Stage data only advances alongside a valid bit, so the last stage holds the last returned word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_granted <= ch_id_t'(NCH - 1);
      for (int s = 0; s < RD_LAT; s++) begin
        pipe_v[s]  <= 1'b0;
        pipe_ch[s] <= '0;
        pipe_d[s]  <= '0;
      end
    end else begin
      if (granted) last_granted <= gnt_idx;
      pipe_v[0] <= granted && !sel_wr;
      if (granted && !sel_wr) begin
        pipe_ch[0] <= gnt_idx;
        pipe_d[0]  <= mem[sel_addr];
      end
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_v[s] <= pipe_v[s-1];
        if (pipe_v[s-1]) begin
          pipe_ch[s] <= pipe_ch[s-1];
          pipe_d[s]  <= pipe_d[s-1];
        end
      end
    end
  end

  always_comb begin
    rd_valid = '0;
    for (int i = 0; i < NCH; i++) begin
      rd_valid[i] = pipe_v[RD_LAT-1] && (pipe_ch[RD_LAT-1] == ch_id_t'(i));
    end
  end

  assign rd_data = pipe_d[RD_LAT-1];

endmodule

// File: tb/tb_sram_arb.sv
// Bench for sram_arb: a 2-channel RD_LAT=1 instance and a 4-channel RD_LAT=3 instance
// checked every cycle against a behavioural model, plus directed literal expectations.
module tb_sram_arb;
  import sram_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  sram_arb_if #(.DATA_W(8), .ADDR_W(8), .NCH(2)) ia (.clk(clk));
  sram_arb_if #(.DATA_W(8), .ADDR_W(8), .NCH(4)) ib (.clk(clk));

  assign ia.rst = rst;
  assign ib.rst = rst;

  sram_arb #(.DATA_W(8), .ADDR_W(8), .NCH(2), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(ia.rst), .en(ia.en), .wr(ia.wr), .wr_data(ia.wr_data), .addr(ia.addr),
    .gnt(ia.gnt), .rd_valid(ia.rd_valid), .rd_data(ia.rd_data)
  );

  sram_arb #(.DATA_W(8), .ADDR_W(8), .NCH(4), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(ib.rst), .en(ib.en), .wr(ib.wr), .wr_data(ib.wr_data), .addr(ib.addr),
    .gnt(ib.gnt), .rd_valid(ib.rd_valid), .rd_data(ib.rd_data)
  );

  // Model state per instance: pointer, memory image, and a return schedule keyed by cycle.
  int         m_ptr  [2];
  logic [7:0] m_mem  [2][256];
  bit         m_sv   [2][8];
  int         m_sch  [2][8];
  logic [7:0] m_sd   [2][8];
  logic [7:0] m_last [2];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int inst, input int nch, input int lat, input logic r,
                            input logic [3:0] e, input logic [3:0] w,
                            input logic [31:0] wd, input logic [31:0] ad,
                            input logic [3:0] g, input logic [3:0] rv, input logic [7:0] rd);
    logic [3:0] exp_g;
    logic [3:0] exp_rv;
    int         win;
    int         slot;
    exp_g  = '0;
    exp_rv = '0;
    win    = -1;
    slot   = cyc % 8;
    if (r) begin
      for (int s = 0; s < 8; s++) m_sv[inst][s] = 1'b0;
      m_ptr[inst]  = nch - 1;
      m_last[inst] = 8'h00;
    end else begin
      for (int off = 1; off <= nch; off++) begin
        if (win < 0 && e[(m_ptr[inst] + off) % nch]) win = (m_ptr[inst] + off) % nch;
      end
      if (win >= 0) exp_g[win] = 1'b1;
      if (m_sv[inst][slot]) begin
        exp_rv[m_sch[inst][slot]] = 1'b1;
        m_last[inst] = m_sd[inst][slot];
      end
    end
    checkOutput($sformatf("gnt[%0d]", inst), {28'b0, g}, {28'b0, exp_g});
    checkOutput($sformatf("onehot0[%0d]", inst), {31'b0, $onehot0(g)}, 32'd1);
    checkOutput($sformatf("rd_valid[%0d]", inst), {28'b0, rv}, {28'b0, exp_rv});
    checkOutput($sformatf("rd_data[%0d]", inst), {24'b0, rd}, {24'b0, m_last[inst]});
    m_sv[inst][slot] = 1'b0;
    if (win >= 0) begin
      m_ptr[inst] = win;
      if (w[win]) begin
        m_mem[inst][ad[win*8 +: 8]] = wd[win*8 +: 8];
      end else begin
        m_sv[inst][(cyc + lat) % 8]  = 1'b1;
        m_sch[inst][(cyc + lat) % 8] = win;
        m_sd[inst][(cyc + lat) % 8]  = m_mem[inst][ad[win*8 +: 8]];
      end
    end
  endtask

  // Inputs only change just after a rising edge, so at the falling edge they describe the next grant edge.
  always @(negedge clk) begin
    model_step(0, 2, 1, rst, {2'b0, ia.en}, {2'b0, ia.wr}, {16'b0, ia.wr_data}, {16'b0, ia.addr},
               {2'b0, ia.gnt}, {2'b0, ia.rd_valid}, ia.rd_data);
    model_step(1, 4, 3, rst, ib.en, ib.wr, ib.wr_data, ib.addr, ib.gnt, ib.rd_valid, ib.rd_data);
    cyc++;
  end

  task automatic applyStimulus(input int inst, input int ch, input logic e, input logic w,
                               input logic [7:0] a, input logic [7:0] d);
    if (inst == 0) begin
      ia.en[ch] = e;
      ia.wr[ch] = w;
      ia.addr[ch*8 +: 8]    = a;
      ia.wr_data[ch*8 +: 8] = d;
    end else begin
      ib.en[ch] = e;
      ib.wr[ch] = w;
      ib.addr[ch*8 +: 8]    = a;
      ib.wr_data[ch*8 +: 8] = d;
    end
  endtask

  task automatic clear_all();
    ia.en = '0;
    ib.en = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: bench did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    ia.en = '0; ia.wr = '0; ia.addr = '0; ia.wr_data = '0;
    ib.en = '0; ib.wr = '0; ib.addr = '0; ib.wr_data = '0;
    tick();
    tick();
    #1;
    checkOutput("reset_gnt_a", {30'b0, ia.gnt}, 32'h0);
    checkOutput("reset_rd_data_a", {24'b0, ia.rd_data}, 32'h0);
    checkOutput("reset_rd_valid_b", {28'b0, ib.rd_valid}, 32'h0);
    rst = 1'b0;

    // Write then read back through channel 0 on the single-cycle instance.
    applyStimulus(0, 0, 1'b1, 1'b1, 8'h10, 8'hA5);
    #1 checkOutput("wr_gnt_a", {30'b0, ia.gnt}, 32'h1);
    tick();
    applyStimulus(0, 0, 1'b1, 1'b0, 8'h10, 8'h00);
    tick();
    clear_all();
    #1;
    checkOutput("rd_valid_a5", {30'b0, ia.rd_valid}, 32'h1);
    checkOutput("rd_data_a5", {24'b0, ia.rd_data}, 32'hA5);

    // Read granted on the edge right after the write must see the new word.
    applyStimulus(0, 1, 1'b1, 1'b1, 8'h20, 8'h3C);
    tick();
    applyStimulus(0, 1, 1'b1, 1'b0, 8'h20, 8'h00);
    tick();
    clear_all();
    #1;
    checkOutput("raw_valid", {30'b0, ia.rd_valid}, 32'h2);
    checkOutput("raw_data", {24'b0, ia.rd_data}, 32'h3C);

    // Both channels reading continuously alternate, with returns one cycle behind.
    applyStimulus(0, 0, 1'b1, 1'b1, 8'h01, 8'h11);
    tick();
    applyStimulus(0, 0, 1'b0, 1'b0, 8'h01, 8'h00);
    applyStimulus(0, 1, 1'b1, 1'b1, 8'h02, 8'h22);
    tick();
    applyStimulus(0, 0, 1'b1, 1'b0, 8'h01, 8'h00);
    applyStimulus(0, 1, 1'b1, 1'b0, 8'h02, 8'h00);
    for (int i = 0; i < 6; i++) begin
      #1;
      checkOutput($sformatf("alt_gnt_%0d", i), {30'b0, ia.gnt}, (i % 2 == 0) ? 32'h1 : 32'h2);
      if (i > 0) begin
        checkOutput($sformatf("alt_rv_%0d", i), {30'b0, ia.rd_valid}, (i % 2 == 1) ? 32'h1 : 32'h2);
        checkOutput($sformatf("alt_rd_%0d", i), {24'b0, ia.rd_data}, (i % 2 == 1) ? 32'h11 : 32'h22);
      end
      tick();
    end
    clear_all();
    #1;
    checkOutput("alt_rv_last", {30'b0, ia.rd_valid}, 32'h2);
    checkOutput("alt_rd_last", {24'b0, ia.rd_data}, 32'h22);

    // Deep-pipeline instance: preload words through channel 1.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 1'b1, 1'b1, 8'h30 + 8'(i), 8'hB0 + 8'(i));
      tick();
    end
    applyStimulus(1, 1, 1'b1, 1'b1, 8'h05, 8'h5A);
    tick();

    // Four back-to-back reads return as four unbroken pulses three cycles later.
    for (int i = 0; i < 8; i++) begin
      if (i < 4) applyStimulus(1, 1, 1'b1, 1'b0, 8'h30 + 8'(i), 8'h00);
      else       clear_all();
      #1;
      checkOutput($sformatf("b2b_rv_%0d", i), {28'b0, ib.rd_valid}, (i >= 3 && i <= 6) ? 32'h2 : 32'h0);
      if (i >= 3 && i <= 6)
        checkOutput($sformatf("b2b_rd_%0d", i), {24'b0, ib.rd_data}, 32'hB0 + 32'(i - 3));
      tick();
    end

    // Reset with two reads in flight: nothing returns, pointers restart at channel 0.
    applyStimulus(1, 1, 1'b1, 1'b0, 8'h05, 8'h00);
    tick();
    tick();
    clear_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("post_rst_rv_b_%0d", i), {28'b0, ib.rd_valid}, 32'h0);
      tick();
    end
    applyStimulus(0, 0, 1'b1, 1'b0, 8'h10, 8'h00);
    applyStimulus(0, 1, 1'b1, 1'b0, 8'h20, 8'h00);
    applyStimulus(1, 0, 1'b1, 1'b0, 8'h05, 8'h00);
    applyStimulus(1, 1, 1'b1, 1'b0, 8'h05, 8'h00);
    #1;
    checkOutput("post_rst_gnt_a", {30'b0, ia.gnt}, 32'h1);
    checkOutput("post_rst_gnt_b", {28'b0, ib.gnt}, 32'h1);
    tick();
    clear_all();
    #1;
    checkOutput("retained_rv_a", {30'b0, ia.rd_valid}, 32'h1);
    checkOutput("retained_rd_a", {24'b0, ia.rd_data}, 32'hA5);
    tick();
    tick();
    checkOutput("retained_rv_b", {28'b0, ib.rd_valid}, 32'h1);
    checkOutput("retained_rd_b", {24'b0, ib.rd_data}, 32'h5A);

    // Sparse requests on four channels: only ch1 and ch3 ever win, alternating.
    applyStimulus(1, 1, 1'b1, 1'b0, 8'h30, 8'h00);
    applyStimulus(1, 3, 1'b1, 1'b0, 8'h31, 8'h00);
    for (int i = 0; i < 8; i++) begin
      #1;
      checkOutput($sformatf("sparse_gnt_%0d", i), {28'b0, ib.gnt}, (i % 2 == 0) ? 32'h2 : 32'h8);
      tick();
    end
    clear_all();
    for (int i = 0; i < 5; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
